// File: rtl/mem_data_port.sv
// Data-memory port for the MEM stage: byte/half/word load-store with
// configurable read latency. Optional debug bus: MEM_DEBUG_BUS_EN.
module mem_data_port #(
    parameter int IO_BUS_SIZE   = 32,
    parameter int MEM_ADDR_SIZE = 5,
    parameter int READ_LATENCY  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_valid,
    input  logic                   i_mem_wr_rd,
    input  logic [1:0]             i_mem_wr_src,
    input  logic [2:0]             i_mem_rd_src,
    input  logic [IO_BUS_SIZE-1:0] i_alu_res,
    input  logic [IO_BUS_SIZE-1:0] i_bus_b,
    output logic                   o_ready,
    output logic                   o_rd_valid,
    output logic [IO_BUS_SIZE-1:0] o_mem_rd,
`ifdef MEM_DEBUG_BUS_EN
    output logic                   o_misalign,
    output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
`else
    output logic                   o_misalign
`endif
);

    localparam int NB       = IO_BUS_SIZE / 8;
    localparam int OFS      = $clog2(NB);
    localparam int DEPTH    = 2 ** MEM_ADDR_SIZE;
    localparam int CNT_INIT = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [IO_BUS_SIZE-1:0]   mem [DEPTH];
    logic [MEM_ADDR_SIZE-1:0] idx;
    logic [OFS-1:0]           off;
    logic [OFS-1:0]           hoff;
    logic                     unused_addr;

    logic [IO_BUS_SIZE-1:0] wr_word;
    logic [IO_BUS_SIZE-1:0] rd_word;
    logic [IO_BUS_SIZE-1:0] rd_ext;
    logic [7:0]             rd_byte;
    logic [15:0]            rd_half;
    logic                   wr_ok;
    logic                   rd_ok;

    logic accept;
    logic st_acc;
    logic ld_acc;
    logic bad;

    logic [2:0]             cnt;
    logic [IO_BUS_SIZE-1:0] load_q;
    logic [IO_BUS_SIZE-1:0] out_q;
    logic                   misalign_q;

    // Upper address bits wrap; half accesses use the even-aligned lane.
    assign idx         = i_alu_res[MEM_ADDR_SIZE+OFS-1:OFS];
    assign off         = i_alu_res[OFS-1:0];
    assign hoff        = {off[OFS-1:1], 1'b0};
    assign unused_addr = ^i_alu_res[IO_BUS_SIZE-1:MEM_ADDR_SIZE+OFS];

    assign accept = i_valid & (state == IDLE) & ~i_flush;
    assign st_acc = accept & i_mem_wr_rd;
    assign ld_acc = accept & ~i_mem_wr_rd;
    assign bad    = (st_acc & ~wr_ok) | (ld_acc & ~rd_ok);

    // Alignment rules for store and load sizes; reserved store size is rejected.
    always_comb begin
        wr_ok = 1'b0;
        rd_ok = 1'b0;
        case (i_mem_wr_src)
            2'b00:   wr_ok = (off == '0);
            2'b01:   wr_ok = ~off[0];
            2'b10:   wr_ok = 1'b1;
            default: wr_ok = 1'b0;
        endcase
        case (i_mem_rd_src)
            3'b001, 3'b010: rd_ok = ~off[0];
            3'b011, 3'b100: rd_ok = 1'b1;
            default:        rd_ok = (off == '0);
        endcase
    end

    // Merge store data into the addressed byte lanes of the current word.
    always_comb begin
        wr_word = mem[idx];
        case (i_mem_wr_src)
            2'b01:   wr_word[{hoff, 3'b000} +: 16] = i_bus_b[15:0];
            2'b10:   wr_word[{off, 3'b000} +: 8]   = i_bus_b[7:0];
            default: wr_word = i_bus_b;
        endcase
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{off, 3'b000} +: 8];
    assign rd_half = rd_word[{hoff, 3'b000} +: 16];

    // Extract and extend the load lane; misaligned loads return zero.
    always_comb begin
        rd_ext = rd_word;
        case (i_mem_rd_src)
            3'b001:  rd_ext = {{(IO_BUS_SIZE-16){rd_half[15]}}, rd_half};
            3'b010:  rd_ext = {{(IO_BUS_SIZE-16){1'b0}}, rd_half};
            3'b011:  rd_ext = {{(IO_BUS_SIZE-8){rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {{(IO_BUS_SIZE-8){1'b0}}, rd_byte};
            default: rd_ext = rd_word;
        endcase
        if (!rd_ok) begin
            rd_ext = '0;
        end
    end

    // Storage: cleared on reset, written at the accepting edge of a legal store.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (st_acc && wr_ok) begin
            mem[idx] <= wr_word;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; flush returns to IDLE from any busy state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_acc) begin
                    state_nxt = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (i_flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; a flush in RESP suppresses the response.
    always_comb begin
        o_ready    = (state == IDLE);
        o_rd_valid = (state == RESP) & ~i_flush;
        o_mem_rd   = o_rd_valid ? load_q : out_q;
        o_misalign = misalign_q;
    end

    // Remaining WAIT cycles before the response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt <= '0;
        end else if (ld_acc) begin
            cnt <= 3'(CNT_INIT);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Load data captured at accept, result held after the response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            load_q     <= '0;
            out_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bad;
            if (ld_acc) begin
                load_q <= rd_ext;
            end
            if (state == RESP && !i_flush) begin
                out_q <= load_q;
            end
        end
    end

`ifdef MEM_DEBUG_BUS_EN
    for (genvar g = 0; g < DEPTH; g++) begin : g_dbg
        assign o_bus_debug[g*IO_BUS_SIZE +: IO_BUS_SIZE] = mem[g];
    end
`endif

endmodule

// File: tb/tb_mem_data_port.sv
// Directed bench for mem_data_port; four instances cover READ_LATENCY 1..4,
// instance 1 (latency 2) is the main one.
module tb_mem_data_port;

    localparam int M = 1;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid;
    logic        wr_rd;
    logic [1:0]  wr_src;
    logic [2:0]  rd_src;
    logic [31:0] alu_res;
    logic [31:0] bus_b;

    logic [3:0]  ready;
    logic [3:0]  rd_valid;
    logic [3:0]  misalign;
    logic [31:0] mem_rd [4];
`ifdef MEM_DEBUG_BUS_EN
    logic [1023:0] dbg [4];
`endif

    int n_pass;
    int n_total;

    for (genvar k = 0; k < 4; k++) begin : g_dut
        mem_data_port #(
            .IO_BUS_SIZE  (32),
            .MEM_ADDR_SIZE(5),
            .READ_LATENCY (k + 1)
        ) u_dut (
            .i_clk       (clk),
            .i_reset     (rst_n),
            .i_flush     (flush),
            .i_valid     (valid),
            .i_mem_wr_rd (wr_rd),
            .i_mem_wr_src(wr_src),
            .i_mem_rd_src(rd_src),
            .i_alu_res   (alu_res),
            .i_bus_b     (bus_b),
            .o_ready     (ready[k]),
            .o_rd_valid  (rd_valid[k]),
            .o_mem_rd    (mem_rd[k]),
`ifdef MEM_DEBUG_BUS_EN
            .o_misalign  (misalign[k]),
            .o_bus_debug (dbg[k])
`else
            .o_misalign  (misalign[k])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] s);
        valid   = 1'b1;
        wr_rd   = 1'b1;
        wr_src  = s;
        alu_res = a;
        bus_b   = d;
        cyc();
        valid   = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] a, input logic [2:0] s,
                            output int lat, output logic [31:0] data,
                            output bit busy_ok, output logic mis1);
        valid   = 1'b1;
        wr_rd   = 1'b0;
        rd_src  = s;
        alu_res = a;
        cyc();
        valid   = 1'b0;
        lat     = 0;
        data    = 'x;
        busy_ok = 1'b1;
        mis1    = misalign[M];
        for (int c = 1; c <= 8; c++) begin
            if (rd_valid[M]) begin
                lat  = c;
                data = mem_rd[M];
                break;
            end
            if (ready[M]) busy_ok = 1'b0;
            cyc();
        end
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) cyc();
        n_total++;
        if (ready[M] !== 1'b1 || rd_valid[M] !== 1'b0 || mem_rd[M] !== 32'h0)
            $display("FAIL reset_hold: rdy=%b vld=%b rd=%h need 1 0 0",
                     ready[M], rd_valid[M], mem_rd[M]);
        else n_pass++;
        rst_n = 1'b1;
        cyc();
        n_total++;
        if (ready !== 4'hF || rd_valid !== 4'h0 || misalign !== 4'h0)
            $display("FAIL reset_after: rdy=%h vld=%h mis=%h need f 0 0",
                     ready, rd_valid, misalign);
        else n_pass++;
`ifdef MEM_DEBUG_BUS_EN
        n_total++;
        if (dbg[M] !== '0)
            $display("FAIL reset_dbg: debug bus not zero");
        else n_pass++;
`endif
    endtask

    task automatic test_load_store();
        int          lat;
        logic [31:0] d;
        bit          bz;
        logic        m;
        drive_store(32'h04, 32'hDEADBEEF, 2'b00);
        run_load(32'h07, 3'b011, lat, d, bz, m);
        n_total++;
        if (d !== 32'hFFFFFFDE || lat != 2 || !bz)
            $display("FAIL ld_byte_s: rd=%h lat=%0d bz=%b need ffffffde 2 1",
                     d, lat, bz);
        else n_pass++;
        n_total++;
        if (rd_valid[M] !== 1'b0 || mem_rd[M] !== 32'hFFFFFFDE)
            $display("FAIL rd_hold: vld=%b rd=%h need 0 ffffffde",
                     rd_valid[M], mem_rd[M]);
        else n_pass++;
        run_load(32'h06, 3'b010, lat, d, bz, m);
        n_total++;
        if (d !== 32'h0000DEAD || lat != 2 || !bz)
            $display("FAIL ld_half_u: rd=%h lat=%0d need 0000dead 2", d, lat);
        else n_pass++;
        run_load(32'h06, 3'b001, lat, d, bz, m);
        n_total++;
        if (d !== 32'hFFFFDEAD)
            $display("FAIL ld_half_s: rd=%h need ffffdead", d);
        else n_pass++;
        run_load(32'h04, 3'b100, lat, d, bz, m);
        n_total++;
        if (d !== 32'h000000EF)
            $display("FAIL ld_byte_u: rd=%h need 000000ef", d);
        else n_pass++;
        run_load(32'h04, 3'b111, lat, d, bz, m);
        n_total++;
        if (d !== 32'hDEADBEEF)
            $display("FAIL ld_word_rsv: rd=%h need deadbeef", d);
        else n_pass++;
    endtask

    task automatic test_lanes();
        int          lat;
        logic [31:0] d;
        bit          bz;
        logic        m;
        drive_store(32'h05, 32'hFFFFFF12, 2'b10);
        n_total++;
        if (ready[M] !== 1'b1 || misalign[M] !== 1'b0)
            $display("FAIL st_ready: rdy=%b mis=%b need 1 0",
                     ready[M], misalign[M]);
        else n_pass++;
        run_load(32'h04, 3'b000, lat, d, bz, m);
        n_total++;
        if (d !== 32'hDEAD12EF)
            $display("FAIL st_byte: rd=%h need dead12ef", d);
        else n_pass++;
        drive_store(32'h0A, 32'h1234CAFE, 2'b01);
        run_load(32'h08, 3'b000, lat, d, bz, m);
        n_total++;
        if (d !== 32'hCAFE0000)
            $display("FAIL st_half: rd=%h need cafe0000", d);
        else n_pass++;
`ifdef MEM_DEBUG_BUS_EN
        n_total++;
        if (dbg[M][95:32] !== 64'hCAFE0000_DEAD12EF)
            $display("FAIL dbg_words: got %h need cafe0000dead12ef",
                     dbg[M][95:32]);
        else n_pass++;
`endif
    endtask

    task automatic test_misalign();
        int          lat;
        logic [31:0] d;
        bit          bz;
        logic        m;
        drive_store(32'h0A, 32'h55555555, 2'b00);
        n_total++;
        if (misalign[M] !== 1'b1)
            $display("FAIL mis_st_pulse: mis=%b need 1", misalign[M]);
        else n_pass++;
        cyc();
        n_total++;
        if (misalign[M] !== 1'b0)
            $display("FAIL mis_st_end: mis=%b need 0", misalign[M]);
        else n_pass++;
        drive_store(32'h08, 32'h66666666, 2'b11);
        n_total++;
        if (misalign[M] !== 1'b1)
            $display("FAIL mis_rsv: mis=%b need 1", misalign[M]);
        else n_pass++;
        run_load(32'h08, 3'b000, lat, d, bz, m);
        n_total++;
        if (d !== 32'hCAFE0000)
            $display("FAIL mis_nowrite: rd=%h need cafe0000", d);
        else n_pass++;
        run_load(32'h03, 3'b001, lat, d, bz, m);
        n_total++;
        if (d !== 32'h0 || lat != 2 || m !== 1'b1)
            $display("FAIL mis_ld: rd=%h lat=%0d mis=%b need 0 2 1", d, lat, m);
        else n_pass++;
    endtask

    task automatic test_flush();
        int          lat;
        logic [31:0] d;
        bit          bz;
        logic        m;
        logic        seen;
        run_load(32'h04, 3'b000, lat, d, bz, m);
        valid   = 1'b1;
        wr_rd   = 1'b0;
        rd_src  = 3'b000;
        alu_res = 32'h08;
        cyc();
        valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        n_total++;
        if (ready[M] !== 1'b1 || rd_valid[M] !== 1'b0)
            $display("FAIL flush_wait: rdy=%b vld=%b need 1 0",
                     ready[M], rd_valid[M]);
        else n_pass++;
        seen = 1'b0;
        repeat (4) begin
            seen |= rd_valid[M];
            cyc();
        end
        n_total++;
        if (seen !== 1'b0 || mem_rd[M] !== 32'hDEAD12EF)
            $display("FAIL flush_noresp: seen=%b rd=%h need 0 dead12ef",
                     seen, mem_rd[M]);
        else n_pass++;
        valid   = 1'b1;
        alu_res = 32'h08;
        cyc();
        valid = 1'b0;
        cyc();
        flush = 1'b1;
        #1;
        n_total++;
        if (rd_valid[M] !== 1'b0 || mem_rd[M] !== 32'hDEAD12EF)
            $display("FAIL flush_resp: vld=%b rd=%h need 0 dead12ef",
                     rd_valid[M], mem_rd[M]);
        else n_pass++;
        cyc();
        flush = 1'b0;
        repeat (3) cyc();
        valid   = 1'b1;
        flush   = 1'b1;
        wr_rd   = 1'b1;
        wr_src  = 2'b00;
        alu_res = 32'h06;
        bus_b   = 32'h0BADF00D;
        cyc();
        valid = 1'b0;
        flush = 1'b0;
        n_total++;
        if (misalign[M] !== 1'b0)
            $display("FAIL flush_nomis: mis=%b need 0", misalign[M]);
        else n_pass++;
        valid   = 1'b1;
        flush   = 1'b1;
        alu_res = 32'h04;
        cyc();
        valid = 1'b0;
        flush = 1'b0;
        run_load(32'h04, 3'b000, lat, d, bz, m);
        n_total++;
        if (d !== 32'hDEAD12EF)
            $display("FAIL flush_nowrite: rd=%h need dead12ef", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] d;
        bit          bz;
        logic        m;
        drive_store(32'h0C, 32'h01020304, 2'b00);
        run_load(32'h0C, 3'b000, lat, d, bz, m);
        n_total++;
        if (d !== 32'h01020304 || lat != 2)
            $display("FAIL b2b: rd=%h lat=%0d need 01020304 2", d, lat);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [3:0] seen;
        valid   = 1'b1;
        wr_rd   = 1'b0;
        rd_src  = 3'b000;
        alu_res = 32'h04;
        cyc();
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        seen  = 4'h0;
        repeat (5) begin
            seen |= rd_valid;
            cyc();
        end
        n_total++;
        if (seen !== 4'h0 || ready !== 4'hF)
            $display("FAIL rst_abort: seen=%h rdy=%h need 0 f", seen, ready);
        else n_pass++;
    endtask

    task automatic test_latency_sweep();
        int          lat [4];
        logic [31:0] dat [4];
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        drive_store(32'h80, 32'h11223344, 2'b00);
        valid   = 1'b1;
        wr_rd   = 1'b0;
        rd_src  = 3'b000;
        alu_res = 32'h00;
        cyc();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lat[k] = 0;
            dat[k] = 'x;
        end
        for (int c = 1; c <= 6; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (rd_valid[k] && lat[k] == 0) begin
                    lat[k] = c;
                    dat[k] = mem_rd[k];
                end
            end
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (lat[k] != k + 1 || dat[k] !== 32'h11223344)
                $display("FAIL sweep_L%0d: lat=%0d rd=%h need %0d 11223344",
                         k + 1, lat[k], dat[k], k + 1);
            else n_pass++;
`ifdef MEM_DEBUG_BUS_EN
            n_total++;
            if (dbg[k][31:0] !== 32'h11223344)
                $display("FAIL sweep_dbg%0d: got %h need 11223344",
                         k, dbg[k][31:0]);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        valid   = 1'b0;
        wr_rd   = 1'b0;
        wr_src  = 2'b00;
        rd_src  = 3'b000;
        alu_res = 32'h0;
        bus_b   = 32'h0;
        test_reset();
        test_load_store();
        test_lanes();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        test_latency_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
